alu_operand_stack: RTL and testbench

- Hardware data stack that feeds the 16-bit ALU its operands and absorbs its results.
- Top two entries are held in registers (TOS, NOS) and driven straight to the ALU A/B inputs; deeper entries spill to a small array.
- One stack operation per clock, selected by the control unit; ALU results write back through this block.

---
 rtl/stack_pkg.sv | 36 +++
 rtl/stack_spill_ram.sv | 40 ++++
 rtl/alu_operand_stack.sv | 101 ++++++++++
 tb/tb_alu_operand_stack.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/stack_pkg.sv
// Opcodes, per-op entry requirements and the legality rule for the ALU operand stack.
package stack_pkg;

  localparam int WIDTH_DEF = 16;

  localparam logic [2:0] OP_NOP  = 3'd0;
  localparam logic [2:0] OP_PUSH = 3'd1;
  localparam logic [2:0] OP_POP  = 3'd2;
  localparam logic [2:0] OP_ALU2 = 3'd3;
  localparam logic [2:0] OP_ALU1 = 3'd4;
  localparam logic [2:0] OP_DUP  = 3'd5;
  localparam logic [2:0] OP_SWAP = 3'd6;

  localparam int NEED_NOP  = 0;
  localparam int NEED_PUSH = 0;
  localparam int NEED_POP  = 1;
  localparam int NEED_ALU2 = 2;
  localparam int NEED_ALU1 = 1;
  localparam int NEED_DUP  = 1;
  localparam int NEED_SWAP = 2;

  // Growing ops additionally need a free slot; opcode 7 is never legal.
  function automatic logic op_legal(input logic [2:0] op, input int cnt, input int depth);
    case (op)
      OP_NOP:  return cnt >= NEED_NOP;
      OP_PUSH: return (cnt >= NEED_PUSH) && (cnt < depth);
      OP_POP:  return cnt >= NEED_POP;
      OP_ALU2: return cnt >= NEED_ALU2;
      OP_ALU1: return cnt >= NEED_ALU1;
      OP_DUP:  return (cnt >= NEED_DUP) && (cnt < depth);
      OP_SWAP: return cnt >= NEED_SWAP;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/stack_spill_ram.sv
// Spill array below TOS/NOS: DEPTH-2 entries, push/pop pointer, unregistered read of the top entry.
module stack_spill_ram #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16,
  parameter int CW    = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] top
);

  localparam int ENTRIES = DEPTH - 2;
  localparam int AW      = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;

  logic [WIDTH-1:0] mem [ENTRIES];
  logic [CW-1:0]    ptr;
  logic [AW-1:0]    top_addr;

  always_ff @(posedge clk) begin
    if (reset)
      ptr <= '0;
    else if (push)
      ptr <= ptr + CW'(1);
    else if (pop)
      ptr <= ptr - CW'(1);
  end

  // NOTE: the array has no reset; entries above ptr are never read, so clearing them buys nothing.
  always_ff @(posedge clk) begin
    if (push)
      mem[ptr[AW-1:0]] <= wdata;
  end

  assign top_addr = AW'(ptr - CW'(1));
  assign top      = (ptr == '0) ? '0 : mem[top_addr];

endmodule

// File: rtl/alu_operand_stack.sv
// ALU operand stack: TOS/NOS registers, entry count, legality check and err.
// Define STACK_ERR_STICKY_EN for a sticky err that traps every non-NOP op until reset.
module alu_operand_stack
  import stack_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int DEPTH = 16,
  parameter int CW    = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             op_valid,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] din,
  input  logic [WIDTH-1:0] alu_r,
  output logic [WIDTH-1:0] tos,
  output logic [WIDTH-1:0] nos,
  output logic [CW-1:0]    count,
  output logic             empty,
  output logic             full,
  output logic             err
);

  logic [WIDTH-1:0] tos_d, nos_d, spill_top;
  logic [CW-1:0]    count_d;
  logic             legal, accept, viol, err_d;
  logic             spill_push, spill_pop, has2, deep;

  stack_spill_ram #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CW(CW)) u_spill (
    .clk   (clk),
    .reset (reset),
    .push  (spill_push),
    .pop   (spill_pop),
    .wdata (nos),
    .top   (spill_top)
  );

  // NOTE: every comb output gets a default first so no path leaves one unassigned (no latches).
  always_comb begin
    tos_d      = tos;
    nos_d      = nos;
    count_d    = count;
    spill_push = 1'b0;
    spill_pop  = 1'b0;
    has2       = count >= CW'(2);
    deep       = count >= CW'(3);
    legal      = op_legal(op, int'(count), DEPTH);
`ifdef STACK_ERR_STICKY_EN
    if (err && op != OP_NOP)
      legal = 1'b0;
`endif
    accept = op_valid && legal;
    viol   = op_valid && !legal;
`ifdef STACK_ERR_STICKY_EN
    err_d = err | viol;
`else
    err_d = viol;
`endif
    if (accept) begin
      case (op)
        OP_PUSH, OP_DUP: begin
          nos_d      = tos;
          tos_d      = (op == OP_PUSH) ? din : tos;
          spill_push = has2;
          count_d    = count + CW'(1);
        end
        OP_POP, OP_ALU2: begin
          tos_d     = (op == OP_POP) ? nos : alu_r;
          nos_d     = deep ? spill_top : '0;
          spill_pop = deep;
          count_d   = count - CW'(1);
        end
        OP_ALU1: tos_d = alu_r;
        OP_SWAP: begin
          tos_d = nos;
          nos_d = tos;
        end
        default: ;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so all of them update from pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      tos   <= '0;
      nos   <= '0;
      count <= '0;
      err   <= 1'b0;
    end else begin
      tos   <= tos_d;
      nos   <= nos_d;
      count <= count_d;
      err   <= err_d;
    end
  end

  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));

endmodule

// File: tb/tb_alu_operand_stack.sv
// Self-checking bench: directed scenarios plus random ops against a queue-based stack model.
module tb_alu_operand_stack;

  localparam int DEPTH = 16;
  localparam int CW    = 5;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        op_valid = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [15:0] din = '0, alu_r = '0;
  logic [15:0] tos, nos;
  logic [CW-1:0] count;
  logic        empty, full, err;

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] st[$];   // st[0] is the top of stack
  bit          err_m;

  alu_operand_stack #(.WIDTH(16), .DEPTH(DEPTH), .CW(CW)) dut (
    .clk(clk), .reset(reset), .op_valid(op_valid), .op(op), .din(din), .alu_r(alu_r),
    .tos(tos), .nos(nos), .count(count), .empty(empty), .full(full), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    logic [15:0] etos, enos;
    etos = (st.size() > 0) ? st[0] : 16'h0;
    enos = (st.size() > 1) ? st[1] : 16'h0;
    check({tag, "_tos"},   32'(tos),   32'(etos));
    check({tag, "_nos"},   32'(nos),   32'(enos));
    check({tag, "_count"}, 32'(count), 32'(st.size()));
    check({tag, "_empty"}, 32'(empty), 32'(st.size() == 0));
    check({tag, "_full"},  32'(full),  32'(st.size() == DEPTH));
    check({tag, "_err"},   32'(err),   32'(err_m));
  endtask

  task automatic model_step(input logic v, input logic [2:0] o, input logic [15:0] d,
                            input logic [15:0] a);
    int n;
    bit leg, viol;
    logic [15:0] t;
    n = st.size();
    case (o)
      3'd0: leg = 1;
      3'd1: leg = n < DEPTH;
      3'd2: leg = n >= 1;
      3'd3: leg = n >= 2;
      3'd4: leg = n >= 1;
      3'd5: leg = (n >= 1) && (n < DEPTH);
      3'd6: leg = n >= 2;
      default: leg = 0;
    endcase
`ifdef STACK_ERR_STICKY_EN
    if (err_m && o != 3'd0) leg = 0;
`endif
    viol = v && !leg;
    if (v && leg) begin
      case (o)
        3'd1: st.push_front(d);
        3'd2: void'(st.pop_front());
        3'd3: begin void'(st.pop_front()); void'(st.pop_front()); st.push_front(a); end
        3'd4: st[0] = a;
        3'd5: st.push_front(st[0]);
        3'd6: begin t = st[0]; st[0] = st[1]; st[1] = t; end
        default: ;
      endcase
    end
`ifdef STACK_ERR_STICKY_EN
    err_m = err_m | viol;
`else
    err_m = viol;
`endif
  endtask

  task automatic do_op(input logic v, input logic [2:0] o, input logic [15:0] d,
                       input logic [15:0] a, input string tag);
    reset = 1'b0; op_valid = v; op = o; din = d; alu_r = a;
    @(posedge clk); #1;
    op_valid = 1'b0;
    model_step(v, o, d, a);
    check_all(tag);
  endtask

  task automatic do_reset(input logic v, input logic [2:0] o, input logic [15:0] d, input string tag);
    reset = 1'b1; op_valid = v; op = o; din = d;
    @(posedge clk); #1;
    reset = 1'b0; op_valid = 1'b0;
    st.delete();
    err_m = 0;
    check_all(tag);
  endtask

  initial begin
    do_reset(1'b0, 3'd0, 16'h0, "reset");

    // Two pushes, then ALU2 consumes both.
    do_op(1, 3'd1, 16'h0003, 16'h0, "push3");
    do_op(1, 3'd1, 16'h0005, 16'h0, "push5");
    check("tp1_tos", 32'(tos), 32'h5);
    check("tp1_nos", 32'(nos), 32'h3);
    check("tp1_count", 32'(count), 32'd2);
    do_op(1, 3'd3, 16'h0, 16'h0008, "alu2");
    check("tp2_tos", 32'(tos), 32'h8);
    check("tp2_nos", 32'(nos), 32'h0);
    check("tp2_count", 32'(count), 32'd1);

    // Fill to DEPTH, overflow, then drain.
    do_reset(1'b0, 3'd0, 16'h0, "reset_fill");
    for (int i = 1; i <= DEPTH; i++) do_op(1, 3'd1, 16'(i), 16'h0, "fill");
    do_op(1, 3'd1, 16'hFFFF, 16'h0, "overflow");
    check("tp3_full", 32'(full), 32'd1);
    check("tp3_tos", 32'(tos), 32'h10);
    check("tp3_count", 32'(count), 32'd16);
    check("tp3_err", 32'(err), 32'd1);
    for (int i = 0; i < DEPTH; i++) do_op(1, 3'd2, 16'h0, 16'h0, "drain");
`ifndef STACK_ERR_STICKY_EN
    check("tp3_empty", 32'(empty), 32'd1);
`endif

    // Underflow from empty.
    do_reset(1'b0, 3'd0, 16'h0, "reset_uf");
    do_op(1, 3'd2, 16'h0, 16'h0, "underflow");
    check("tp4_err", 32'(err), 32'd1);
    check("tp4_count", 32'(count), 32'd0);
    do_op(1, 3'd1, 16'h0042, 16'h0, "push42");
`ifdef STACK_ERR_STICKY_EN
    check("tp4_trap_count", 32'(count), 32'd0);
    check("tp4_trap_err", 32'(err), 32'd1);
`else
    check("tp4_tos", 32'(tos), 32'h42);
    check("tp4_err_pulse", 32'(err), 32'd0);
`endif

    // SWAP then DUP.
    do_reset(1'b0, 3'd0, 16'h0, "reset_sw");
    do_op(1, 3'd1, 16'h0055, 16'h0, "push55");
    do_op(1, 3'd1, 16'h00AA, 16'h0, "pushAA");
    do_op(1, 3'd6, 16'h0, 16'h0, "swap");
    check("tp5_tos", 32'(tos), 32'h55);
    check("tp5_nos", 32'(nos), 32'hAA);
    do_op(1, 3'd5, 16'h0, 16'h0, "dup");
    check("tp5_dup_tos", 32'(tos), 32'h55);
    check("tp5_dup_nos", 32'(nos), 32'h55);
    check("tp5_dup_count", 32'(count), 32'd3);

    // Reset beats a simultaneous PUSH, also clearing a pending err.
    do_op(1, 3'd7, 16'h0, 16'h0, "illegal7");
    do_reset(1'b1, 3'd1, 16'h1234, "reset_push");
    check("tp6_count", 32'(count), 32'd0);
    check("tp6_tos", 32'(tos), 32'h0);
    check("tp6_err", 32'(err), 32'd0);

    // Random ops, push-biased, with occasional resets.
    for (int i = 0; i < 800; i++) begin
      logic v;
      logic [2:0] o;
      if ($urandom_range(0, 49) == 0) begin
        do_reset(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 16'($urandom), "rnd_reset");
      end else begin
        v = ($urandom_range(0, 9) != 0);
        o = ($urandom_range(0, 9) < 3) ? 3'd1 : 3'($urandom_range(0, 7));
        do_op(v, o, 16'($urandom), 16'($urandom), "rnd");
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
